// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
// fetch_entry_t fixes the {instr, pc, pc4} layout of one prefetch queue entry.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int DEPTH_DEFAULT = 4;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0]             instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with single-cycle flush; DEPTH must be a power of two.
// The head entry is always visible on rdata_o; push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_comb begin
    doPop   = pop_i && !empty_o;
    doPush  = push_i && (!full_o || doPop);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches, reserves a queue slot per
// in-flight request, buffers responses for decode and discards stale responses after a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_instr,
  output logic [XLEN-1:0]            dec_pc,
  output logic [XLEN-1:0]            dec_pc4,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam int              ENTRY_W = 32 + 2 * XLEN;
  localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0]    fetchPc_q, fetchPc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   dropCount_q, dropCount_d;
  logic [CNT_W:0]     inFlight;
  logic               reqFire, rspKeep, decFire;
  logic [XLEN-1:0]    rspPc;
  logic [ENTRY_W-1:0] pushEntry, headEntry;
  logic               qEmpty, qFull, shadowEmpty, shadowFull;
  logic [CNT_W-1:0]   shadowCount;
  logic               unusedFifoStatus;

  // outstanding includes responses already marked for dropping, so the slot check stays conservative.
  assign inFlight       = {1'b0, occupancy} + {1'b0, outstanding_q};
  assign imem_req_valid = !reset && !redirect_valid && (inFlight < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = fetchPc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;
  assign rspKeep        = imem_rsp_valid && !redirect_valid && (dropCount_q == '0);
  assign dec_valid      = !reset && !redirect_valid && !qEmpty;
  assign decFire        = dec_valid && dec_ready;
  assign pushEntry      = {imem_rsp_data, rspPc, rspPc + STEP};

  always_comb begin
    fetchPc_d     = fetchPc_q;
    outstanding_d = outstanding_q + CNT_W'(reqFire) - CNT_W'(imem_rsp_valid);
    dropCount_d   = dropCount_q;
    if (redirect_valid) begin
      fetchPc_d   = redirect_pc;
      dropCount_d = outstanding_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (reqFire) fetchPc_d = fetchPc_q + STEP;
      if (imem_rsp_valid && (dropCount_q != '0)) dropCount_d = dropCount_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q     <= RESET_PC;
      outstanding_q <= '0;
      dropCount_q   <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      outstanding_q <= outstanding_d;
      dropCount_q   <= dropCount_d;
    end
  end

  always_comb begin
    dec_instr = '0;
    dec_pc    = '0;
    dec_pc4   = '0;
    if (!qEmpty) {dec_instr, dec_pc, dec_pc4} = headEntry;
  end

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) entryQueue (
    .clk    (clk),
    .reset  (reset),
    .flush_i(redirect_valid),
    .push_i (rspKeep),
    .wdata_i(pushEntry),
    .pop_i  (decFire),
    .rdata_o(headEntry),
    .full_o (qFull),
    .empty_o(qEmpty),
    .count_o(occupancy)
  );

  // Addresses of live requests, oldest first; the head pairs with the next kept response.
  sync_fifo #(
    .WIDTH(XLEN),
    .DEPTH(DEPTH)
  ) shadowQueue (
    .clk    (clk),
    .reset  (reset),
    .flush_i(redirect_valid),
    .push_i (reqFire),
    .wdata_i(fetchPc_q),
    .pop_i  (rspKeep),
    .rdata_o(rspPc),
    .full_o (shadowFull),
    .empty_o(shadowEmpty),
    .count_o(shadowCount)
  );

  assign unusedFifoStatus = ^{qFull, shadowFull, shadowEmpty, shadowCount};

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a fixed-latency memory model answers requests, directed
// scenarios queue the entries decode must see, and a monitor checks every decode handshake.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pc4;
  logic [2:0]  occupancy;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t      pending[$];
  fetch_entry_t expQ[$];
  int           checks = 0;
  int           errors = 0;
  int           cycleCnt = 0;
  int           reqCount = 0;
  int           memLatency = 1;

  fetch_unit #(
    .XLEN(32),
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_pc4       (dec_pc4),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  // Memory model: word at addr reads as addr ^ 0xDEAD0000, returned memLatency cycles after acceptance.
  always begin
    memReq_t r;
    @(negedge clk);
    if (reset) begin
      pending.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      pending.push_back('{addr: imem_req_addr, due: cycleCnt + memLatency});
      reqCount++;
    end
    @(posedge clk);
    #1;
    cycleCnt++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pending.size() > 0 && pending[0].due <= cycleCnt) begin
      r = pending.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = r.addr ^ 32'hDEAD0000;
    end
  end

  always begin
    fetch_entry_t exp;
    @(negedge clk);
    if (dec_valid && dec_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL dec_entry: got unexpected pop instr=%h pc=%h pc4=%h, expected no pop",
                 dec_instr, dec_pc, dec_pc4);
      end else begin
        exp = expQ.pop_front();
        if (dec_instr !== exp.instr || dec_pc !== exp.pc || dec_pc4 !== exp.pc4) begin
          errors++;
          $display("[TB] FAIL dec_entry: got instr=%h pc=%h pc4=%h, expected instr=%h pc=%h pc4=%h",
                   dec_instr, dec_pc, dec_pc4, exp.instr, exp.pc, exp.pc4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic reqRdy, input logic decRdy,
                               input logic redir, input logic [31:0] redirPc);
    reset          = rst;
    imem_req_ready = reqRdy;
    dec_ready      = decRdy;
    redirect_valid = redir;
    redirect_pc    = redirPc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic expectEntry(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
    expQ.push_back('{instr: instr, pc: pc, pc4: pc4});
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    reqCount = 0;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    $display("[TB] reset state");
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("rst_dec_valid", 32'(dec_valid), 32'h0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
    checkOutput("rst_dec_instr", dec_instr, 32'h0);
    checkOutput("rst_dec_pc", dec_pc, 32'h0);
    checkOutput("rst_dec_pc4", dec_pc4, 32'h0);

    $display("[TB] streaming with 1-cycle memory");
    doReset();
    memLatency = 1;
    for (int i = 0; i < 8; i++) expectEntry(32'hDEAD0000 + 32'(4 * i), 32'(4 * i), 32'(4 * i + 4));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("stream_first_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("stream_first_req_addr", imem_req_addr, 32'h0);
    checkOutput("stream_c0_dec_valid", 32'(dec_valid), 32'h0);
    stepCycle();
    checkOutput("stream_c1_dec_valid", 32'(dec_valid), 32'h0);
    checkOutput("stream_c1_req_addr", imem_req_addr, 32'h4);
    stepCycle();
    checkOutput("stream_c2_dec_valid", 32'(dec_valid), 32'h1);
    checkOutput("stream_c2_dec_pc", dec_pc, 32'h0);
    repeat (5) stepCycle();
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) stepCycle();
    checkOutput("stream_req_count", 32'(reqCount), 32'd8);
    checkOutput("stream_hold_addr", imem_req_addr, 32'h20);
    checkOutput("stream_sb_empty", 32'(expQ.size()), 32'h0);

    $display("[TB] decode backpressure");
    doReset();
    expectEntry(32'hDEAD0000, 32'h0, 32'h4);
    expectEntry(32'hDEAD0004, 32'h4, 32'h8);
    expectEntry(32'hDEAD0008, 32'h8, 32'hC);
    expectEntry(32'hDEAD000C, 32'hC, 32'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (8) stepCycle();
    checkOutput("bp_req_count", 32'(reqCount), 32'd4);
    checkOutput("bp_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("bp_occupancy", 32'(occupancy), 32'd4);
    checkOutput("bp_head_pc", dec_pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) stepCycle();
    checkOutput("bp_drain_occupancy", 32'(occupancy), 32'h0);
    checkOutput("bp_sb_empty", 32'(expQ.size()), 32'h0);
    checkOutput("bp_stall_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("bp_stall_addr", imem_req_addr, 32'h10);
    stepCycle();
    checkOutput("bp_stall_addr_held", imem_req_addr, 32'h10);

    $display("[TB] flush with two responses in flight");
    doReset();
    memLatency = 3;
    expectEntry(32'hDEAD0100, 32'h100, 32'h104);
    expectEntry(32'hDEAD0104, 32'h104, 32'h108);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("flush_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("flush_dec_valid", 32'(dec_valid), 32'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("flush_new_addr", imem_req_addr, 32'h100);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (6) stepCycle();
    checkOutput("flush_sb_empty", 32'(expQ.size()), 32'h0);
    checkOutput("flush_occupancy", 32'(occupancy), 32'h0);

    $display("[TB] back-to-back redirects");
    doReset();
    memLatency = 3;
    expectEntry(32'hDEAD0400, 32'h400, 32'h404);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h400);
    checkOutput("b2b_req_valid", 32'(imem_req_valid), 32'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("b2b_target_addr", imem_req_addr, 32'h400);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (5) stepCycle();
    checkOutput("b2b_sb_empty", 32'(expQ.size()), 32'h0);

    $display("[TB] address wrap");
    doReset();
    memLatency = 1;
    expectEntry(32'h2152FFFC, 32'hFFFFFFFC, 32'h0);
    expectEntry(32'hDEAD0000, 32'h0, 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFC);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_first_addr", imem_req_addr, 32'hFFFFFFFC);
    stepCycle();
    checkOutput("wrap_next_addr", imem_req_addr, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_dec_pc", dec_pc, 32'hFFFFFFFC);
    checkOutput("wrap_dec_pc4", dec_pc4, 32'h0);
    repeat (4) stepCycle();
    checkOutput("wrap_sb_empty", 32'(expQ.size()), 32'h0);

    $display("[TB] redirect with pop attempt and response arriving");
    doReset();
    memLatency = 1;
    expectEntry(32'hDEAD0200, 32'h200, 32'h204);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    checkOutput("simul_dec_valid", 32'(dec_valid), 32'h0);
    checkOutput("simul_rsp_present", 32'(imem_rsp_valid), 32'h1);
    checkOutput("simul_occ_before", 32'(occupancy), 32'h1);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("simul_occ_after", 32'(occupancy), 32'h0);
    checkOutput("simul_dec_valid_after", 32'(dec_valid), 32'h0);
    checkOutput("simul_new_addr", imem_req_addr, 32'h200);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) stepCycle();
    checkOutput("simul_sb_empty", 32'(expQ.size()), 32'h0);

    $display("[TB] reset with a full queue");
    doReset();
    memLatency = 1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (8) stepCycle();
    checkOutput("mid_full_occupancy", 32'(occupancy), 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_in_reset_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("mid_in_reset_dec_valid", 32'(dec_valid), 32'h0);
    expectEntry(32'hDEAD0000, 32'h0, 32'h4);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("mid_occupancy", 32'(occupancy), 32'h0);
    checkOutput("mid_dec_valid", 32'(dec_valid), 32'h0);
    checkOutput("mid_dec_instr", dec_instr, 32'h0);
    checkOutput("mid_dec_pc", dec_pc, 32'h0);
    checkOutput("mid_dec_pc4", dec_pc4, 32'h0);
    checkOutput("mid_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("mid_req_addr", imem_req_addr, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) stepCycle();
    checkOutput("mid_sb_empty", 32'(expQ.size()), 32'h0);
    checkOutput("mid_end_occupancy", 32'(occupancy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
